// File: rtl/demux_2bits_buf.sv
// 1-to-4 buffered demultiplexer: one holding register plus valid/ready per channel.
// Optional per-channel accepted-transfer counters are enabled by defining DEMUX_CONT_EN.
module demux_2bits_buf #(
    parameter int LARGURA      = 8,
    parameter int CONT_LARGURA = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              controle,
    input  logic [LARGURA-1:0]      entrada,
    input  logic                    valid_in,
    output logic                    ready_in,
    output logic [LARGURA-1:0]      saida1,
    output logic [LARGURA-1:0]      saida2,
    output logic [LARGURA-1:0]      saida3,
    output logic [LARGURA-1:0]      saida4,
    output logic [3:0]              valid_out,
`ifdef DEMUX_CONT_EN
    input  logic [3:0]              ready_out,
    output logic [CONT_LARGURA-1:0] cont1,
    output logic [CONT_LARGURA-1:0] cont2,
    output logic [CONT_LARGURA-1:0] cont3,
    output logic [CONT_LARGURA-1:0] cont4
`else
    input  logic [3:0]              ready_out
`endif
);

    logic [LARGURA-1:0] r_dados [4];
    logic [3:0]         r_valid;
    logic [3:0]         w_load;

    // A channel accepts when empty or when its consumer drains it this same cycle.
    assign ready_in = !r_valid[controle] | ready_out[controle];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_canal
            assign w_load[gi] = valid_in & ready_in & (controle == 2'(gi));

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_valid[gi] <= 1'b0;
                    r_dados[gi] <= '0;
                end else if (w_load[gi]) begin
                    r_valid[gi] <= 1'b1;
                    r_dados[gi] <= entrada;
                end else if (ready_out[gi]) begin
                    r_valid[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign valid_out = r_valid;
    assign saida1    = r_dados[0];
    assign saida2    = r_dados[1];
    assign saida3    = r_dados[2];
    assign saida4    = r_dados[3];

`ifdef DEMUX_CONT_EN
    logic [CONT_LARGURA-1:0] r_cont [4];

    generate
        for (gi = 0; gi < 4; gi++) begin : g_cont
            // Wraps naturally at 2^CONT_LARGURA.
            always_ff @(posedge clock) begin
                if (reset)
                    r_cont[gi] <= '0;
                else if (w_load[gi])
                    r_cont[gi] <= r_cont[gi] + 1'b1;
            end
        end
    endgenerate

    assign cont1 = r_cont[0];
    assign cont2 = r_cont[1];
    assign cont3 = r_cont[2];
    assign cont4 = r_cont[3];
`endif

endmodule
